// File: rtl/xbar_pkg.sv
// Shared types and constants for the two-master crossbar arbiter.
// MASTER0/MASTER1 are also the encodings of the response mux select.
package xbar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic MASTER0 = 1'b0;
   localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/arb_timer.sv
// Grant-hold timer: counts owned cycles without ack and saturates.
// o_expired flags the cycle whose count step reaches TIMEOUT_CYCLES-1.
module arb_timer #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
   localparam logic [W-1:0] PRE  = W'(TIMEOUT_CYCLES - 2);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_enable && (r_cnt == PRE);

endmodule

// File: rtl/xbar_arbiter.sv
// Two-master round-robin arbiter for a shared slave path, with a
// forced release when the owner holds the grant too long without ack.
module xbar_arbiter
   import xbar_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_ack,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_sel,
   output logic o_busy,
   output logic o_timeout
);

   arb_state_t r_state;
   logic       r_last;
   logic       w_clear;
   logic       w_enable;
   logic       w_expired;

   // Any cycle that cannot continue the current ownership restarts the count.
   assign w_clear  = (r_state == IDLE) || i_ack || o_timeout;
   assign w_enable = !w_clear;

   arb_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_clear),
      .i_enable (w_enable),
      .o_expired(w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last    <= MASTER1;
         o_gnt0    <= 1'b0;
         o_gnt1    <= 1'b0;
         o_sel     <= MASTER0;
         o_busy    <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_req0 && (!i_req1 || (r_last == MASTER1))) begin
                  r_state <= OWN0;
                  o_gnt0  <= 1'b1;
                  o_sel   <= MASTER0;
                  o_busy  <= 1'b1;
               end else if (i_req1) begin
                  r_state <= OWN1;
                  o_gnt1  <= 1'b1;
                  o_sel   <= MASTER1;
                  o_busy  <= 1'b1;
               end
            end
            OWN0: begin
               if (i_ack || o_timeout) begin
                  r_last <= MASTER0;
                  o_gnt0 <= 1'b0;
                  if (i_ack && i_req1) begin
                     r_state <= OWN1;
                     o_gnt1  <= 1'b1;
                     o_sel   <= MASTER1;
                  end else begin
                     r_state <= IDLE;
                     o_busy  <= 1'b0;
                  end
               end else if (w_expired) begin
                  o_timeout <= 1'b1;
               end
            end
            OWN1: begin
               if (i_ack || o_timeout) begin
                  r_last <= MASTER1;
                  o_gnt1 <= 1'b0;
                  if (i_ack && i_req0) begin
                     r_state <= OWN0;
                     o_gnt0  <= 1'b1;
                     o_sel   <= MASTER0;
                  end else begin
                     r_state <= IDLE;
                     o_busy  <= 1'b0;
                  end
               end else if (w_expired) begin
                  o_timeout <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               o_gnt0  <= 1'b0;
               o_gnt1  <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Randomized and directed bench for xbar_arbiter against a
// cycle-level ownership model.
module tb_xbar_arbiter;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_req0 = 1'b0;
   logic i_req1 = 1'b0;
   logic i_ack = 1'b0;
   logic o_gnt0;
   logic o_gnt1;
   logic o_sel;
   logic o_busy;
   logic o_timeout;

   int checks = 0;
   int failures = 0;

   // Model: owner (-1 none), cycles owned, pulse flag, last served.
   int m_own;
   int m_last;
   int m_sel;
   int m_k;
   bit m_to;

   always #5 clk = ~clk;

   xbar_arbiter #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req0   (i_req0),
      .i_req1   (i_req1),
      .i_ack    (i_ack),
      .o_gnt0   (o_gnt0),
      .o_gnt1   (o_gnt1),
      .o_sel    (o_sel),
      .o_busy   (o_busy),
      .o_timeout(o_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_own = -1;
      m_last = 1;
      m_sel = 0;
      m_k = 0;
      m_to = 1'b0;
   endtask

   task automatic m_step(input bit r0, input bit r1, input bit a);
      int oth;
      bit oreq;
      if (m_own < 0) begin
         m_to = 1'b0;
         if (r0 && r1) m_own = (m_last == 1) ? 0 : 1;
         else if (r0) m_own = 0;
         else if (r1) m_own = 1;
         if (m_own >= 0) begin
            m_sel = m_own;
            m_k = 1;
         end
      end else if (a) begin
         oth = 1 - m_own;
         oreq = (oth == 1) ? r1 : r0;
         m_last = m_own;
         m_to = 1'b0;
         if (oreq) begin
            m_own = oth;
            m_sel = oth;
            m_k = 1;
         end else begin
            m_own = -1;
         end
      end else if (m_to) begin
         m_last = m_own;
         m_own = -1;
         m_to = 1'b0;
      end else begin
         m_k++;
         m_to = (m_k == T);
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, "_gnt0"}, 32'(o_gnt0), 32'(m_own == 0));
      chk({tag, "_gnt1"}, 32'(o_gnt1), 32'(m_own == 1));
      chk({tag, "_sel"}, 32'(o_sel), 32'(m_sel));
      chk({tag, "_busy"}, 32'(o_busy), 32'(m_own >= 0));
      chk({tag, "_tmo"}, 32'(o_timeout), 32'(m_to));
   endtask

   task automatic cyc(input bit r0, input bit r1, input bit a);
      @(negedge clk);
      cmp_all("model");
      i_req0 = r0;
      i_req1 = r1;
      i_ack = a;
      @(posedge clk);
      m_step(r0, r1, a);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      i_req0 = 1'b0;
      i_req1 = 1'b0;
      i_ack = 1'b0;
      m_reset();
      @(negedge clk);
      cmp_all("reset");
      rst = 1'b0;
   endtask

   initial begin
      bit r0;
      bit r1;
      bit a;
      m_reset();
      do_reset();

      cyc(1, 0, 0);
      chk("r030_gnt0", 32'(o_gnt0), 32'd1);
      chk("r030_sel", 32'(o_sel), 32'd0);
      chk("r030_busy", 32'(o_busy), 32'd1);
      cyc(0, 0, 1);

      do_reset();
      cyc(1, 1, 0);
      chk("r031_gnt0", 32'(o_gnt0), 32'd1);
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 1);
      chk("r031_gnt1", 32'(o_gnt1), 32'd1);
      chk("r031_sel", 32'(o_sel), 32'd1);

      cyc(0, 0, 1);
      cyc(1, 1, 0);
      chk("r032_tie0", 32'(o_gnt0), 32'd1);
      cyc(1, 0, 1);
      chk("r032_bubble", 32'(o_busy), 32'd0);
      cyc(1, 0, 0);
      chk("r032_regnt", 32'(o_gnt0), 32'd1);
      cyc(0, 0, 1);

      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("r033_pulse", 32'(o_timeout), 32'd1);
      chk("r033_gnt1", 32'(o_gnt1), 32'd1);
      cyc(0, 0, 0);
      chk("r033_idle", 32'(o_busy), 32'd0);
      chk("r033_sel", 32'(o_sel), 32'd1);
      chk("r033_nopls", 32'(o_timeout), 32'd0);

      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("r034_tmo", 32'(o_timeout), 32'd0);
      chk("r034_idle", 32'(o_busy), 32'd0);

      cyc(0, 1, 0);
      chk("r035_own1", 32'(o_gnt1), 32'd1);
      #1;
      rst = 1'b1;
      i_req1 = 1'b0;
      m_reset();
      #1;
      chk("r035_gnt1", 32'(o_gnt1), 32'd0);
      chk("r035_sel", 32'(o_sel), 32'd0);
      chk("r035_busy", 32'(o_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 1, 0);
      chk("r035_tie0", 32'(o_gnt0), 32'd1);

      for (int n = 0; n < 600; n++) begin
         r0 = (i_req0 && m_own != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         r1 = (i_req1 && m_own != 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
         a = ($urandom_range(0, 4) == 0);
         cyc(r0, r1, a);
         if ($urandom_range(0, 199) == 0) do_reset();
      end
      @(negedge clk);
      cmp_all("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xbar_arbiter.md
XBAR_ARBITER -- requirements
Module: xbar_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: max cycles a grant is held without i_ack; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_req0  in  1  master 0 transaction request, level, held until granted.
REQ-005 SHALL have port i_req1  in  1  master 1 transaction request, level, held until granted.
REQ-006 SHALL have port i_ack  in  1  slave response-complete strobe for the granted master.
REQ-007 SHALL have port o_gnt0  out  1  master 0 owns the slave path.
REQ-008 SHALL have port o_gnt1  out  1  master 1 owns the slave path.
REQ-009 SHALL have port o_sel  out  1  read-response mux select, 0 = MASTER0, 1 = MASTER1.
REQ-010 SHALL have port o_busy  out  1  a grant is active.
REQ-011 SHALL have port o_timeout  out  1  one-cycle pulse when a grant is force-released.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1; all outputs SHALL be registered.
REQ-013 SHALL keep a 1-bit last-served pointer; on a tie, priority goes to the master not last served.
REQ-014 IDLE: any request SHALL move the FSM to the OWN state of the winner; grant is visible 1 cycle after request is sampled.
REQ-015 IDLE with no request SHALL remain in IDLE.
REQ-016 OWNx SHALL hold o_gntx=1, o_sel=x, o_busy=1 regardless of the state of i_reqx.
REQ-017 OWNx with i_ack=1: next state SHALL be OWN(other) if the other request is high, else IDLE; last-served SHALL become x.
REQ-018 The same master SHALL NOT be re-granted directly from OWNx; a still-high i_reqx SHALL be re-arbitrated from IDLE.
REQ-019 i_ack in IDLE SHALL be ignored.
REQ-020 o_gnt0 and o_gnt1 SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-021 o_sel SHALL hold the last owner value in IDLE so the downstream mux output stays stable.
REQ-022 The timeout counter SHALL clear on every OWN entry and increment each OWN cycle without i_ack.
REQ-023 When the count reaches TIMEOUT_CYCLES-1 without i_ack, the block SHALL pulse o_timeout for 1 cycle, go to IDLE, and set last-served = x.
REQ-024 Simultaneous i_ack and timeout SHALL be treated as ack: no o_timeout pulse, REQ-017 applies.
REQ-025 Counter width SHALL be $clog2(TIMEOUT_CYCLES); the counter SHALL never wrap.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, o_gnt0=0, o_gnt1=0, o_sel=0, o_busy=0, o_timeout=0, counter=0, last-served=1 (master 0 wins the first tie).
REQ-027 rst asserted mid-grant SHALL drop the grant asynchronously; after release, arbitration SHALL restart from IDLE on the next edge.

Structure
REQ-028 Package xbar_pkg SHALL hold the arb_state_t enum (IDLE, OWN0, OWN1) and the MASTER0=0 / MASTER1=1 constants shared with the response mux.
REQ-029 The timeout counter SHALL be a sub-module arb_timer (inputs: clear, enable; output: expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-030 Reset, then i_req0=1 at cycle 0 -> o_gnt0=1, o_sel=0, o_busy=1 at cycle 1.
REQ-031 Both requests high from IDLE after reset -> master 0 granted; i_ack at cycle 3 -> o_gnt1=1, o_sel=1 at cycle 4 with no IDLE bubble.
REQ-032 Master 1 served last, then both request -> master 0 granted; master 0 re-requests after ack while master 1 idle -> IDLE for 1 cycle, then master 0 granted.
REQ-033 TIMEOUT_CYCLES=4, grant to master 1, no i_ack -> o_timeout pulse on the 4th OWN1 cycle, IDLE next cycle, o_sel stays 1.
REQ-034 TIMEOUT_CYCLES=4, i_ack coincides with expiry -> o_timeout stays 0, normal release.
REQ-035 rst pulsed during OWN1 -> o_gnt1=0 and o_sel=0 immediately; after rst drops, a tie grants master 0.
